// File: rtl/piezo_arb_pkg.sv
// rtl/piezo_arb_pkg.sv - shared constants, FSM encoding and priority helpers for piezo_arbiter
package piezo_arb_pkg;

    localparam int NUM_REQ = 5;

    localparam int ENGINE_IDX  = 0;
    localparam int TURN_IDX    = 1;
    localparam int REVERSE_IDX = 2;
    localparam int ESS_IDX     = 3;
    localparam int HORN_IDX    = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PLAY = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    // One-hot of the highest set request bit (higher index wins).
    function automatic logic [NUM_REQ-1:0] pick_highest(input logic [NUM_REQ-1:0] r);
        logic [NUM_REQ-1:0] g;
        g = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (r[i]) begin
                g    = '0;
                g[i] = 1'b1;
            end
        end
        return g;
    endfunction

    // Mask of requester bits strictly above the one-hot owner.
    function automatic logic [NUM_REQ-1:0] above_mask(input logic [NUM_REQ-1:0] owner);
        logic [NUM_REQ-1:0] m;
        logic               seen;
        m    = '0;
        seen = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            m[i] = seen;
            seen = seen | owner[i];
        end
        return m;
    endfunction

endpackage

// File: rtl/tone_gen.sv
// rtl/tone_gen.sv - half-period counter and toggle flop producing the piezo square wave
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   en           count while high; wave forced low when low
//   clear        restart the tone: counter and wave back to zero
//   half_period  live half-period in clk cycles; zero holds the wave low
//   wave         square-wave output
module tone_gen
    import piezo_arb_pkg::*;
#(
    parameter int HP_W = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            en,
    input  logic            clear,
    input  logic [HP_W-1:0] half_period,
    output logic            wave
);

    logic [HP_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt  <= '0;
            wave <= 1'b0;
        end else if (clear || !en || (half_period == '0)) begin
            cnt  <= '0;
            wave <= 1'b0;
        end else if (cnt >= half_period - HP_W'(1)) begin
            // ">=" so a live shrink below the running count toggles at once
            cnt  <= '0;
            wave <= ~wave;
        end else begin
            cnt <= cnt + HP_W'(1);
        end
    end

endmodule

// File: rtl/piezo_arbiter.sv
// rtl/piezo_arbiter.sv - fixed-priority piezo tone arbiter with hold time and silent gap
//
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   tick_1ms      one-clk strobe every millisecond
//   mute          forces idle and silence
//   req[4:0]      engine, turn, reverse, ESS, horn (horn highest)
//   half_period   packed half-periods, slice i belongs to req[i]
//   grant         one-hot current owner
//   piezo_out     square-wave drive
//   active        high while a tone is playing
// Build option: PIEZO_ARB_HORN_PREEMPT_EN lets the horn take over immediately.
module piezo_arbiter
    import piezo_arb_pkg::*;
#(
    parameter int HP_W    = 16,
    parameter int HOLD_MS = 20,
    parameter int GAP_MS  = 5
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    tick_1ms,
    input  logic                    mute,
    input  logic [NUM_REQ-1:0]      req,
    input  logic [NUM_REQ*HP_W-1:0] half_period,
    output logic [NUM_REQ-1:0]      grant,
    output logic                    piezo_out,
    output logic                    active
);

    localparam int HOLD_W = $clog2(HOLD_MS + 1);
    localparam int GAP_W  = $clog2(GAP_MS + 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(HOLD_MS);
    localparam logic [GAP_W-1:0]  GAP_LAST = GAP_W'(GAP_MS - 1);

    state_t               state_q, state_d;
    logic [NUM_REQ-1:0]   grant_q, grant_d;
    logic [HOLD_W-1:0]    hold_q, hold_d;
    logic [GAP_W-1:0]     gap_q, gap_d;
    logic                 tone_clear;
    logic [HP_W-1:0]      hp_sel;

    always_comb begin
        hp_sel = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_q[i]) hp_sel = half_period[i*HP_W +: HP_W];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
            hold_q  <= '0;
            gap_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            hold_q  <= hold_d;
            gap_q   <= gap_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        hold_d     = hold_q;
        gap_d      = gap_q;
        tone_clear = 1'b0;
        case (state_q)
            ST_IDLE: begin
                grant_d    = '0;
                hold_d     = '0;
                gap_d      = '0;
                tone_clear = 1'b1;
                if (|req) begin
                    grant_d = pick_highest(req);
                    state_d = ST_PLAY;
                end
            end
            ST_PLAY: begin
                if (tick_1ms && (hold_q != HOLD_MAX)) hold_d = hold_q + HOLD_W'(1);
                // Owner drop is checked first so it wins over a coincident preemption.
                if ((req & grant_q) == '0) begin
                    state_d    = ST_GAP;
                    grant_d    = '0;
                    gap_d      = '0;
                    tone_clear = 1'b1;
                end
`ifdef PIEZO_ARB_HORN_PREEMPT_EN
                else if (req[HORN_IDX] && !grant_q[HORN_IDX]) begin
                    grant_d          = '0;
                    grant_d[HORN_IDX] = 1'b1;
                    hold_d           = '0;
                    tone_clear       = 1'b1;
                end
`endif
                else if (|(req & above_mask(grant_q)) && (hold_q == HOLD_MAX)) begin
                    state_d    = ST_GAP;
                    grant_d    = '0;
                    gap_d      = '0;
                    tone_clear = 1'b1;
                end
            end
            ST_GAP: begin
                grant_d    = '0;
                tone_clear = 1'b1;
                if (tick_1ms) begin
                    if (gap_q == GAP_LAST) begin
                        state_d = ST_IDLE;
                        gap_d   = '0;
                    end else begin
                        gap_d = gap_q + GAP_W'(1);
                    end
                end
            end
            default: begin
                state_d    = ST_IDLE;
                grant_d    = '0;
                tone_clear = 1'b1;
            end
        endcase
        if (mute) begin
            state_d    = ST_IDLE;
            grant_d    = '0;
            hold_d     = '0;
            gap_d      = '0;
            tone_clear = 1'b1;
        end
    end

    tone_gen #(.HP_W(HP_W)) u_tone_gen (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (state_q == ST_PLAY),
        .clear       (tone_clear),
        .half_period (hp_sel),
        .wave        (piezo_out)
    );

    assign grant  = grant_q;
    assign active = (state_q == ST_PLAY);

endmodule

// File: tb/tb_piezo_arbiter.sv
// tb/tb_piezo_arbiter.sv - randomized self-checking bench for piezo_arbiter against a behavioural model
module tb_piezo_arbiter;

    localparam int HP_W     = 16;
    localparam int HOLD     = 20;
    localparam int GAP      = 5;
    localparam int TICK_DIV = 16;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            tick_1ms;
    logic            mute;
    logic [4:0]      req;
    logic [5*HP_W-1:0] hp_bus;
    logic [4:0]      grant;
    logic            piezo_out;
    logic            active;

    int n_cmp = 0;
    int n_fail = 0;
    int tick_cnt = 0;

    always #5 clk = ~clk;

    piezo_arbiter #(.HP_W(HP_W), .HOLD_MS(HOLD), .GAP_MS(GAP)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .tick_1ms    (tick_1ms),
        .mute        (mute),
        .req         (req),
        .half_period (hp_bus),
        .grant       (grant),
        .piezo_out   (piezo_out),
        .active      (active)
    );

    // Behavioural model: owner as an index, hold and gap as millisecond counts,
    // tone as cycles elapsed since the last edge of the wave.
    int   m_owner   = -1;
    int   m_mode    = 0;   // 0 idle, 1 playing, 2 silent gap
    int   m_hold    = 0;
    int   m_gap     = 0;
    int   m_elapsed = 0;
    logic m_wave    = 1'b0;

    always @(posedge clk or negedge rst_n) begin : model
        int hp;
        int hold_before;
        bit higher;
        if (!rst_n || mute) begin
            m_owner = -1; m_mode = 0; m_hold = 0; m_gap = 0; m_elapsed = 0; m_wave = 1'b0;
        end else if (m_mode == 0) begin
            if (req != 5'b0) begin
                for (int i = 0; i < 5; i++) if (req[i]) m_owner = i;
                m_mode = 1; m_hold = 0; m_elapsed = 0; m_wave = 1'b0;
            end
        end else if (m_mode == 1) begin
            higher = 0;
            for (int i = m_owner + 1; i < 5; i++) if (req[i]) higher = 1;
            hold_before = m_hold;
            if (tick_1ms && m_hold < HOLD) m_hold++;
            if (!req[m_owner]) begin
                m_mode = 2; m_owner = -1; m_gap = 0; m_wave = 1'b0; m_elapsed = 0;
            end
`ifdef PIEZO_ARB_HORN_PREEMPT_EN
            else if (req[4] && m_owner != 4) begin
                m_owner = 4; m_hold = 0; m_elapsed = 0; m_wave = 1'b0;
            end
`endif
            else if (higher && hold_before == HOLD) begin
                m_mode = 2; m_owner = -1; m_gap = 0; m_wave = 1'b0; m_elapsed = 0;
            end else begin
                hp = int'(hp_bus[m_owner*HP_W +: HP_W]);
                if (hp == 0) begin
                    m_wave = 1'b0; m_elapsed = 0;
                end else begin
                    m_elapsed++;
                    if (m_elapsed >= hp) begin
                        m_wave = ~m_wave; m_elapsed = 0;
                    end
                end
            end
        end else begin
            if (tick_1ms) begin
                m_gap++;
                if (m_gap >= GAP) begin
                    m_mode = 0; m_gap = 0;
                end
            end
        end
    end

    function automatic logic [4:0] exp_grant();
        return (m_owner < 0) ? 5'b0 : 5'(1 << m_owner);
    endfunction

    task automatic step();
        tick_1ms = (tick_cnt == TICK_DIV - 1);
        tick_cnt = (tick_cnt == TICK_DIV - 1) ? 0 : tick_cnt + 1;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic go_idle();
        req  = 5'b0;
        mute = 1'b1;
        step();
        mute = 1'b0;
        step();
    endtask

    task automatic test_reset();
        req = 5'b11111;
        repeat (2) @(negedge clk);
        n_cmp++; if (grant !== 5'b0) begin n_fail++; $display("FAIL reset_grant: got %b want 00000", grant); end
        n_cmp++; if (piezo_out !== 1'b0) begin n_fail++; $display("FAIL reset_piezo: got %b want 0", piezo_out); end
        n_cmp++; if (active !== 1'b0) begin n_fail++; $display("FAIL reset_active: got %b want 0", active); end
        req   = 5'b0;
        rst_n = 1'b1;
        step();
        n_cmp++; if (grant !== 5'b0) begin n_fail++; $display("FAIL reset_idle_grant: got %b want 00000", grant); end
    endtask

    task automatic test_engine_tone();
        int toggles;
        int first_at;
        int last_at;
        logic prev;
        go_idle();
        hp_bus[0*HP_W +: HP_W] = 16'd100;
        req = 5'b00001;
        step();
        n_cmp++; if (grant !== 5'b00001) begin n_fail++; $display("FAIL engine_grant: got %b want 00001", grant); end
        n_cmp++; if (active !== 1'b1) begin n_fail++; $display("FAIL engine_active: got %b want 1", active); end
        n_cmp++; if (piezo_out !== 1'b0) begin n_fail++; $display("FAIL engine_start_low: got %b want 0", piezo_out); end
        toggles = 0; first_at = -1; last_at = 0; prev = piezo_out;
        for (int k = 1; k <= 320; k++) begin
            step();
            n_cmp++; if (piezo_out !== m_wave) begin n_fail++; $display("FAIL engine_wave: got %b want %b cyc %0d", piezo_out, m_wave, k); end
            if (piezo_out !== prev) begin
                if (first_at < 0) first_at = k;
                else begin
                    n_cmp++; if (k - last_at !== 100) begin n_fail++; $display("FAIL engine_period: got %0d want 100", k - last_at); end
                end
                last_at = k; toggles++;
            end
            prev = piezo_out;
        end
        n_cmp++; if (first_at !== 100) begin n_fail++; $display("FAIL engine_first_toggle: got %0d want 100", first_at); end
        n_cmp++; if (toggles !== 3) begin n_fail++; $display("FAIL engine_toggles: got %0d want 3", toggles); end
    endtask

    task automatic test_hold_preempt();
        int ticks;
        int gap_ticks;
        bit left;
        bit got;
        go_idle();
        hp_bus[0*HP_W +: HP_W] = 16'd10;
        hp_bus[2*HP_W +: HP_W] = 16'd7;
        req = 5'b00001;
        step();
        ticks = 0;
        while (ticks < 3) begin step(); if (tick_1ms) ticks++; end
        req = 5'b00101;
        left = 0; got = 0; gap_ticks = 0;
        for (int k = 0; k < 1500 && !got; k++) begin
            step();
            if (tick_1ms) begin if (left) gap_ticks++; else ticks++; end
            n_cmp++; if (grant !== exp_grant()) begin n_fail++; $display("FAIL hold_grant: got %b want %b", grant, exp_grant()); end
            n_cmp++; if (piezo_out !== m_wave) begin n_fail++; $display("FAIL hold_wave: got %b want %b", piezo_out, m_wave); end
            if (!left && grant !== 5'b00001) begin
                left = 1;
                n_cmp++; if (ticks !== HOLD) begin n_fail++; $display("FAIL hold_ms: got %0d want %0d", ticks, HOLD); end
                n_cmp++; if (grant !== 5'b0) begin n_fail++; $display("FAIL hold_gap_grant: got %b want 00000", grant); end
            end
            if (grant === 5'b00100) got = 1;
        end
        n_cmp++; if (!got) begin n_fail++; $display("FAIL hold_new_owner: got %b want 00100 (timeout)", grant); end
        n_cmp++; if (gap_ticks !== GAP) begin n_fail++; $display("FAIL hold_gap_ms: got %0d want %0d", gap_ticks, GAP); end
    endtask

    task automatic test_horn();
        int ticks;
        bit got;
        go_idle();
        hp_bus[0*HP_W +: HP_W] = 16'd10;
        hp_bus[4*HP_W +: HP_W] = 16'd50;
        req = 5'b00001;
        step();
        ticks = 0;
        while (ticks < 2) begin step(); if (tick_1ms) ticks++; end
        req = 5'b10001;
        step();
`ifdef PIEZO_ARB_HORN_PREEMPT_EN
        n_cmp++; if (grant !== 5'b10000) begin n_fail++; $display("FAIL horn_next: got %b want 10000", grant); end
`else
        n_cmp++; if (grant !== 5'b00001) begin n_fail++; $display("FAIL horn_wait: got %b want 00001", grant); end
`endif
        got = 0;
        for (int k = 0; k < 1500 && !got; k++) begin
            step();
            n_cmp++; if (grant !== exp_grant()) begin n_fail++; $display("FAIL horn_grant: got %b want %b", grant, exp_grant()); end
            n_cmp++; if (piezo_out !== m_wave) begin n_fail++; $display("FAIL horn_wave: got %b want %b", piezo_out, m_wave); end
            if (grant === 5'b10000 && k > 120) got = 1;
        end
        n_cmp++; if (!got) begin n_fail++; $display("FAIL horn_owner: got %b want 10000 (timeout)", grant); end
    endtask

    task automatic test_drop_and_rise();
        int ticks;
        bit got;
        go_idle();
        hp_bus[0*HP_W +: HP_W] = 16'd9;
        hp_bus[3*HP_W +: HP_W] = 16'd6;
        req = 5'b00001;
        repeat (5) step();
        req = 5'b01000;
        step();
        n_cmp++; if (grant !== 5'b0) begin n_fail++; $display("FAIL drop_grant: got %b want 00000", grant); end
        n_cmp++; if (active !== 1'b0) begin n_fail++; $display("FAIL drop_active: got %b want 0", active); end
        n_cmp++; if (piezo_out !== 1'b0) begin n_fail++; $display("FAIL drop_piezo: got %b want 0", piezo_out); end
        ticks = 0; got = 0;
        for (int k = 0; k < 300 && !got; k++) begin
            step();
            if (tick_1ms) ticks++;
            n_cmp++; if (grant !== exp_grant()) begin n_fail++; $display("FAIL drop_gap_grant: got %b want %b", grant, exp_grant()); end
            if (grant === 5'b01000) got = 1;
        end
        n_cmp++; if (!got) begin n_fail++; $display("FAIL drop_new_owner: got %b want 01000 (timeout)", grant); end
        n_cmp++; if (ticks !== GAP) begin n_fail++; $display("FAIL drop_gap_ms: got %0d want %0d", ticks, GAP); end
    endtask

    task automatic test_reset_mid_play();
        bit high;
        go_idle();
        hp_bus[0*HP_W +: HP_W] = 16'd4;
        req = 5'b00001;
        high = 0;
        for (int k = 0; k < 20 && !high; k++) begin step(); if (piezo_out === 1'b1) high = 1; end
        n_cmp++; if (!high) begin n_fail++; $display("FAIL midplay_high: got %b want 1 (timeout)", piezo_out); end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++; if (grant !== 5'b0) begin n_fail++; $display("FAIL async_grant: got %b want 00000", grant); end
        n_cmp++; if (piezo_out !== 1'b0) begin n_fail++; $display("FAIL async_piezo: got %b want 0", piezo_out); end
        n_cmp++; if (active !== 1'b0) begin n_fail++; $display("FAIL async_active: got %b want 0", active); end
        @(negedge clk);
        rst_n = 1'b1;
        step();
        n_cmp++; if (grant !== 5'b00001) begin n_fail++; $display("FAIL post_reset_grant: got %b want 00001", grant); end
        mute = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            n_cmp++; if ({grant, piezo_out, active} !== 7'b0) begin n_fail++; $display("FAIL mute_idle: got %b/%b/%b want 00000/0/0", grant, piezo_out, active); end
        end
        mute = 1'b0;
    endtask

    task automatic test_hp_zero();
        go_idle();
        hp_bus[0*HP_W +: HP_W] = 16'd200;
        req = 5'b00001;
        step();
        repeat (210) step();
        n_cmp++; if (piezo_out !== 1'b1) begin n_fail++; $display("FAIL hp200_high: got %b want 1", piezo_out); end
        hp_bus[0*HP_W +: HP_W] = 16'd0;
        for (int k = 0; k < 40; k++) begin
            step();
            n_cmp++; if ({grant, piezo_out, active} !== 7'b0000101) begin n_fail++; $display("FAIL hp_zero: got %b/%b/%b want 00001/0/1", grant, piezo_out, active); end
        end
    endtask

    task automatic test_random();
        go_idle();
        for (int i = 0; i < 5; i++) hp_bus[i*HP_W +: HP_W] = HP_W'($urandom_range(20));
        for (int k = 0; k < 6000; k++) begin
            if ($urandom_range(49) == 0) req[$urandom_range(4)] = 1'b1;
            if ($urandom_range(199) == 0) req[$urandom_range(4)] = 1'b0;
            if ($urandom_range(29) == 0) hp_bus[$urandom_range(4)*HP_W +: HP_W] = HP_W'($urandom_range(20));
            mute = ($urandom_range(499) == 0);
            step();
            n_cmp++; if (grant !== exp_grant()) begin n_fail++; $display("FAIL rand_grant: got %b want %b cyc %0d", grant, exp_grant(), k); end
            n_cmp++; if (piezo_out !== m_wave) begin n_fail++; $display("FAIL rand_wave: got %b want %b cyc %0d", piezo_out, m_wave, k); end
            n_cmp++; if (active !== (m_mode == 1)) begin n_fail++; $display("FAIL rand_active: got %b want %b cyc %0d", active, (m_mode == 1), k); end
            n_cmp++; if (!$onehot0(grant)) begin n_fail++; $display("FAIL rand_onehot: got %b want at most one bit", grant); end
        end
        mute = 1'b0;
    endtask

    initial begin
        rst_n    = 1'b0;
        mute     = 1'b0;
        req      = 5'b0;
        tick_1ms = 1'b0;
        hp_bus   = '0;
        test_reset();
        test_engine_tone();
        test_hold_preempt();
        test_horn();
        test_drop_and_rise();
        test_reset_mid_play();
        test_hp_zero();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/piezo_arbiter.md
PIEZO_ARBITER -- requirements
Module: piezo_arbiter

Interface
REQ-001 SHALL have parameter HP_W, default 16, width of each tone half-period in clk cycles.
REQ-002 SHALL have parameter HOLD_MS, default 20, minimum grant time in ms before lower-to-higher preemption.
REQ-003 SHALL have parameter GAP_MS, default 5, silent gap in ms between consecutive grants.
REQ-004 SHALL have port clk  in  1  system clock; the single clock of the block.
REQ-005 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have port tick_1ms  in  1  one-clk strobe every 1 ms.
REQ-007 SHALL have port mute  in  1  forces silence and idle when high.
REQ-008 SHALL have port req  in  5  requests: bit0 engine, bit1 turn, bit2 reverse, bit3 ESS, bit4 horn.
REQ-009 SHALL have port half_period  in  5*HP_W  packed half-periods, slice i belongs to req[i].
REQ-010 SHALL have port grant  out  5  one-hot current owner, all-zero when none.
REQ-011 SHALL have port piezo_out  out  1  square-wave drive to piezo.
REQ-012 SHALL have port active  out  1  high while in PLAY.

Function
REQ-013 SHALL implement FSM states IDLE, PLAY, GAP.
REQ-014 IDLE: on any req bit with mute low, grant highest set index next clk, enter PLAY; piezo_out starts low.
REQ-015 Priority SHALL be fixed: horn > ESS > reverse > turn > engine.
REQ-016 PLAY: hold counter SHALL count tick_1ms pulses from grant, saturating at HOLD_MS.
REQ-017 PLAY: if owner drops req, enter GAP next clk, grant cleared, piezo_out low.
REQ-018 PLAY: higher-priority req with hold counter == HOLD_MS SHALL end grant and enter GAP.
REQ-019 GAP: piezo_out low, grant zero; after GAP_MS tick_1ms pulses return to IDLE and re-arbitrate.
REQ-020 Tone: clk counter increments each clk in PLAY; when counter >= half_period[owner]-1, toggle piezo_out and clear counter.
REQ-021 half_period SHALL be read live (engine tone tracks RPM); a decrease below current count toggles on next clk.
REQ-022 half_period[owner] == 0 SHALL hold piezo_out low while grant stays valid.
REQ-023 Tone and hold counters SHALL clear on every new grant; no wrap of hold counter.
REQ-024 mute high SHALL, next clk, force IDLE, grant zero, piezo_out low, active low, from any state.
REQ-025 Simultaneous owner drop and higher-priority request SHALL take the drop path (GAP).
REQ-026 grant SHALL never have more than one bit set.

Reset
REQ-027 rst_n low SHALL asynchronously force IDLE, grant=0, piezo_out=0, active=0, all counters 0.
REQ-028 Reset mid-PLAY SHALL silence immediately; after release normal arbitration resumes from IDLE.

Configuration
REQ-029 Macro PIEZO_ARB_HORN_PREEMPT_EN defined: horn request SHALL preempt any owner immediately, bypassing HOLD_MS and GAP (owner switch in one clk, tone counter cleared).
REQ-030 Macro undefined: horn SHALL obey REQ-018 like any requester.

Structure
REQ-031 Package piezo_arb_pkg SHALL hold requester index constants, FSM state encoding, NUM_REQ=5.
REQ-032 Sub-module tone_gen SHALL contain the half-period counter and toggle flop (en, half_period, clear in; wave out).

Verification
REQ-033 req=5'b00001, hp[0]=100 -> grant=00001 after 1 clk, piezo_out toggles every 100 clk.
REQ-034 engine playing 3 ms, req[2] rises -> no switch until 20 ms, then 5 ms silent GAP, grant=00100.
REQ-035 macro defined, engine playing 2 ms, req[4] rises, hp[4]=50 -> grant=10000 next clk, toggles every 50 clk; macro undefined -> waits to 20 ms.
REQ-036 owner drop together with req[3] rise -> GAP 5 ms, then grant=01000.
REQ-037 rst_n low mid-PLAY -> grant=0, piezo_out=0 same cycle without clk edge; mute=1 -> idle next clk.
REQ-038 hp[owner] changed 200 -> 0 during PLAY -> piezo_out low, grant unchanged, active=1.
